// File: rtl/signal_conflict_monitor.sv
// ---------------------------------------------------------------------------
// signal_conflict_monitor
//
// Safety stage between the T-intersection light controller and the lamp
// drivers. The four controller lamp codes are registered and passed through
// to the lamps. Every cycle the inputs are checked for three things:
//   - conflicting permissive indications (S against any main lane, MT
//     against M2),
//   - codes that are not one-hot,
//   - a lane jumping straight from green to red. This check is only built
//     when SCM_YELLOW_CHECK_EN is defined.
// A confirmed fault latches, drives all lamps flashing red and holds the
// controller in reset. The fault is left only through an accepted operator
// clear followed by an all-red recovery interval.
//
// Lamp codes: 100 red, 010 yellow, 001 green (000 = dark, flash off-phase).
//
// Compile-time option:
//   SCM_YELLOW_CHECK_EN  defined   -> cause 4 (skipped yellow) detection
//                        undefined -> cause 4 never raised, no history regs
//
// Parameters:
//   FILTER_CYC  consecutive cycles a cause 1-3 must persist (1..255)
//   ALLRED_CYC  all-red cycles after reset / after a cleared fault (1..255)
//   FLASH_HALF  cycles per flash half-period while in FAULT (1..255)
//
// Ports:
//   clk                       clock
//   rst                       asynchronous active-high reset
//   in_M1/in_M2/in_MT/in_S    controller lamp codes
//   clr_req                   operator fault-clear pulse
//   lamp_M1/M2/MT/S           registered lamp drive
//   fault                     latched fault indication
//   fault_code                cause of latched fault, 0 = none
//                             (1 S conflict, 2 MT/M2 conflict, 3 invalid,
//                              4 skipped yellow)
//   fault_cnt                 saturating count of fault entries since reset
//   ctl_hold                  high in RECOVER and FAULT (controller reset)
//   state_dbg                 current FSM state (0 RECOVER, 1 RUN, 2 FAULT)
//
// clr_req protocol: a single-cycle request with no acknowledge. It is
// acted on only in FAULT, and only in a cycle where no cause 1-3 is present
// on the inputs. A request that is not acted on is dropped, not remembered.
// ---------------------------------------------------------------------------
module signal_conflict_monitor #(
    parameter int unsigned FILTER_CYC = 2,
    parameter int unsigned ALLRED_CYC = 4,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_M1,
    input  logic [2:0] in_M2,
    input  logic [2:0] in_MT,
    input  logic [2:0] in_S,
    input  logic       clr_req,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_cnt,
    output logic       ctl_hold,
    output logic [1:0] state_dbg
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    // Terminal values of the cycle counters (count runs 0 .. N-1).
    localparam logic [7:0] FILT_LAST   = 8'(FILTER_CYC - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYC - 1);
    localparam logic [7:0] FLASH_LAST  = 8'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_RECOVER = 2'd0,
        ST_RUN     = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rcnt_q,  rcnt_d;    // all-red cycle counter
    logic [7:0]      filt_q,  filt_d;    // cause 1-3 persistence filter
    logic [7:0]      fcnt_q,  fcnt_d;    // flash half-period counter
    logic            phase_q, phase_d;   // flash phase: 0 red, 1 dark
    logic [3:0][2:0] lamps_q, lamps_d;   // index 0 M1, 1 M2, 2 MT, 3 S
    logic            fault_q, fault_d;
    logic [2:0]      code_q,  code_d;
    logic [7:0]      cnt_q,   cnt_d;

    logic [3:0][2:0] in_all;
    logic            cause1, cause2, cause3, cause4;
    logic            cause_filt;         // any filtered cause (1-3) present
    logic            confirm;            // fault confirmed at this edge
    logic [2:0]      cause_code;         // lowest present cause, 0 if none

    // Yellow or green: the lamp lets traffic move.
    function automatic logic is_perm(input logic [2:0] c);
        return (c == YELLOW) || (c == GREEN);
    endfunction

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    assign in_all = {in_S, in_MT, in_M2, in_M1};

    // M1 with M2 and M1 with MT are legal overlaps and are not checked.
    assign cause1 = is_perm(in_S) &&
                    (is_perm(in_M1) || is_perm(in_M2) || is_perm(in_MT));
    assign cause2 = is_perm(in_MT) && is_perm(in_M2);
    assign cause3 = !is_onehot(in_M1) || !is_onehot(in_M2) ||
                    !is_onehot(in_MT) || !is_onehot(in_S);
    assign cause_filt = cause1 || cause2 || cause3;

`ifdef SCM_YELLOW_CHECK_EN
    // Per-lane history of the previous RUN cycle's code. It is primed to red
    // on entry to RUN so that the first RUN cycle can never look like a
    // green-to-red jump.
    logic [3:0][2:0] prev_q;
    logic [3:0]      skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= {4{RED}};
        end else if ((state_q == ST_RECOVER) && (state_d == ST_RUN)) begin
            prev_q <= {4{RED}};
        end else if (state_q == ST_RUN) begin
            prev_q <= in_all;
        end
    end

    always_comb begin
        skip = '0;
        for (int i = 0; i < 4; i++) begin
            skip[i] = (prev_q[i] == GREEN) && (in_all[i] == RED);
        end
    end

    assign cause4 = |skip;
`else
    assign cause4 = 1'b0;
`endif

    // Priority encode: the lowest-numbered present cause is reported.
    always_comb begin
        cause_code = 3'd0;
        if (cause1) begin
            cause_code = 3'd1;
        end else if (cause2) begin
            cause_code = 3'd2;
        end else if (cause3) begin
            cause_code = 3'd3;
        end else if (cause4) begin
            cause_code = 3'd4;
        end
    end

    // Causes 1-3 confirm on their FILTER_CYC-th consecutive sample; the
    // skipped-yellow cause is a single-edge event and bypasses the filter.
    assign confirm = (cause_filt && (filt_q == FILT_LAST)) || cause4;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RECOVER;
            rcnt_q  <= '0;
            filt_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            lamps_q <= {4{RED}};
            fault_q <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            lamps_q <= lamps_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        filt_d  = '0;            // filter only lives in RUN
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        lamps_d = lamps_q;
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RECOVER: begin
                lamps_d = {4{RED}};
                if (rcnt_q == ALLRED_LAST) begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end

            ST_RUN: begin
                lamps_d = in_all;
                if (cause_filt && (filt_q != 8'hff)) begin
                    filt_d = filt_q + 8'd1;
                end
                if (confirm) begin
                    // Fault outputs appear on the confirming edge; the flash
                    // starts with a full red half-period.
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = cause_code;
                    if (cnt_q != 8'hff) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    lamps_d = {4{RED}};
                    fcnt_d  = '0;
                    phase_d = 1'b0;
                    filt_d  = '0;
                end
            end

            ST_FAULT: begin
                if (clr_req && !cause_filt) begin
                    state_d = ST_RECOVER;
                    fault_d = 1'b0;
                    code_d  = '0;
                    rcnt_d  = '0;
                    fcnt_d  = '0;
                    phase_d = 1'b0;
                    lamps_d = {4{RED}};
                end else if (fcnt_q == FLASH_LAST) begin
                    fcnt_d  = '0;
                    phase_d = ~phase_q;
                    // Lamps follow the phase being entered.
                    lamps_d = phase_q ? {4{RED}} : {4{DARK}};
                end else begin
                    fcnt_d  = fcnt_q + 8'd1;
                    lamps_d = phase_q ? {4{DARK}} : {4{RED}};
                end
            end

            default: begin
                state_d = ST_RECOVER;
                rcnt_d  = '0;
                lamps_d = {4{RED}};
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign lamp_M1    = lamps_q[0];
    assign lamp_M2    = lamps_q[1];
    assign lamp_MT    = lamps_q[2];
    assign lamp_S     = lamps_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_cnt  = cnt_q;
    assign ctl_hold   = (state_q != ST_RUN);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tb_signal_conflict_monitor
//
// Directed bench for signal_conflict_monitor with default parameters
// (FILTER_CYC 2, ALLRED_CYC 4, FLASH_HALF 4). Each driven cycle pushes the
// hand-derived output vector expected after the following rising edge; a
// monitor pops one entry after every rising edge and compares.
// Expected vector layout: {M1, M2, MT, S, fault, fault_code, fault_cnt,
// ctl_hold}.
// ---------------------------------------------------------------------------
module tb_signal_conflict_monitor;

    localparam int FLASH_HALF = 4;
    localparam int ALLRED_CYC = 4;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] D   = 3'b000;
    localparam logic [2:0] BAD = 3'b011;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT
    // -----------------------------------------------------------------------
    logic       clk;
    logic       rst;
    logic [2:0] in_M1, in_M2, in_MT, in_S;
    logic       clr_req;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;
    logic       ctl_hold;
    logic [1:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    signal_conflict_monitor #(
        .FILTER_CYC(2),
        .ALLRED_CYC(ALLRED_CYC),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_M1(in_M1),
        .in_M2(in_M2),
        .in_MT(in_MT),
        .in_S(in_S),
        .clr_req(clr_req),
        .lamp_M1(lamp_M1),
        .lamp_M2(lamp_M2),
        .lamp_MT(lamp_MT),
        .lamp_S(lamp_S),
        .fault(fault),
        .fault_code(fault_code),
        .fault_cnt(fault_cnt),
        .ctl_hold(ctl_hold),
        .state_dbg(state_dbg)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [24:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  exp_cnt  = 8'd0;   // fault entries expected so far
    logic [2:0]  exp_code = 3'd0;
    int          flash_k  = 0;      // cycles since FAULT entry

    function automatic logic [24:0] ev(input logic [2:0] m1, input logic [2:0] m2,
                                       input logic [2:0] mt, input logic [2:0] s,
                                       input logic f, input logic [2:0] c,
                                       input logic [7:0] n, input logic h);
        return {m1, m2, mt, s, f, c, n, h};
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step(input logic r, input logic [2:0] m1, input logic [2:0] m2,
                        input logic [2:0] mt, input logic [2:0] s, input logic clr,
                        input logic [24:0] e, input string tag);
        @(negedge clk);
        rst     = r;
        in_M1   = m1;
        in_M2   = m2;
        in_MT   = mt;
        in_S    = s;
        clr_req = clr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // RUN cycle without fault: lamps equal the inputs sampled at this edge.
    task automatic run(input string tag, input logic [2:0] m1, input logic [2:0] m2,
                       input logic [2:0] mt, input logic [2:0] s);
        step(1'b0, m1, m2, mt, s, 1'b0, ev(m1, m2, mt, s, 1'b0, 3'd0, exp_cnt, 1'b0), tag);
    endtask

    // Remaining RECOVER edges (after reset release or after the clear edge):
    // ALLRED_CYC-1 held edges, then the edge entering RUN (lamps still red).
    task automatic allred(input string tag);
        for (int i = 0; i < ALLRED_CYC - 1; i++) begin
            step(1'b0, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, exp_cnt, 1'b1), tag);
        end
        step(1'b0, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, exp_cnt, 1'b0),
             {tag, "_enter_run"});
    endtask

    task automatic enter_fault(input string tag, input logic [2:0] m1, input logic [2:0] m2,
                               input logic [2:0] mt, input logic [2:0] s,
                               input logic [2:0] code);
        exp_code = code;
        exp_cnt  = exp_cnt + 8'd1;
        flash_k  = 1;
        step(1'b0, m1, m2, mt, s, 1'b0, ev(R, R, R, R, 1'b1, code, exp_cnt, 1'b1), tag);
    endtask

    // FAULT cycles: red for FLASH_HALF cycles (entry included), then dark.
    task automatic flash(input string tag, input int n, input logic [2:0] m1,
                         input logic [2:0] m2, input logic [2:0] mt,
                         input logic [2:0] s, input logic clr);
        logic [2:0] l;
        for (int i = 0; i < n; i++) begin
            l = (((flash_k / FLASH_HALF) % 2) == 0) ? R : D;
            step(1'b0, m1, m2, mt, s, clr, ev(l, l, l, l, 1'b1, exp_code, exp_cnt, 1'b1), tag);
            flash_k++;
        end
    endtask

    task automatic clear_fault(input string tag);
        step(1'b0, R, R, R, R, 1'b1, ev(R, R, R, R, 1'b0, 3'd0, exp_cnt, 1'b1), tag);
        allred({tag, "_allred"});
    endtask

    // -----------------------------------------------------------------------
    // Monitor: one comparison after every rising edge that has an entry
    // -----------------------------------------------------------------------
    logic [24:0] mon_exp, mon_got;
    string       mon_tag;

    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            #1;
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_got = {lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code, fault_cnt, ctl_hold};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got M1=%b M2=%b MT=%b S=%b fault=%b code=%0d cnt=%0d hold=%b (state %0d); required M1=%b M2=%b MT=%b S=%b fault=%b code=%0d cnt=%0d hold=%b",
                         mon_tag, $time,
                         mon_got[24:22], mon_got[21:19], mon_got[18:16], mon_got[15:13],
                         mon_got[12], mon_got[11:9], mon_got[8:1], mon_got[0], state_dbg,
                         mon_exp[24:22], mon_exp[21:19], mon_exp[18:16], mon_exp[15:13],
                         mon_exp[12], mon_exp[11:9], mon_exp[8:1], mon_exp[0]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [11:0] legal_seq [0:5];

    initial begin
        rst     = 1'b1;
        in_M1   = R;
        in_M2   = R;
        in_MT   = R;
        in_S    = R;
        clr_req = 1'b0;

        legal_seq[0] = {G, G, R, R};   // M1/M2 green
        legal_seq[1] = {G, Y, R, R};   // M2 yellow
        legal_seq[2] = {G, R, G, R};   // MT green
        legal_seq[3] = {Y, R, Y, R};   // M1/MT yellow
        legal_seq[4] = {R, R, R, G};   // S green
        legal_seq[5] = {R, R, R, Y};   // S yellow

        // Reset state, then release with all-red inputs.
        step(1'b1, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "reset");
        step(1'b1, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "reset");
        allred("release");
        run("first_pass", G, R, R, R);

        // Legal controller sequence, three loops.
        for (int loop = 0; loop < 3; loop++) begin
            for (int j = 0; j < 6; j++) begin
                run("legal", legal_seq[j][11:9], legal_seq[j][8:6],
                    legal_seq[j][5:3], legal_seq[j][2:0]);
            end
        end

        // Isolated single-cycle conflicts (S yellow with M1 green) never latch.
        run("one_cyc_pre", G, R, R, R);
        run("one_cyc_conf", G, R, R, Y);
        run("one_cyc_clean", G, R, R, R);
        run("one_cyc_conf2", G, R, R, Y);
        run("one_cyc_clean2", G, R, R, R);

        // clr_req in RUN is ignored.
        step(1'b0, G, R, R, R, 1'b1, ev(G, R, R, R, 1'b0, 3'd0, exp_cnt, 1'b0), "clr_in_run");

        // S green with M1 green held two cycles: first edge passes through,
        // second edge latches cause 1.
        run("conf_first", G, R, R, G);
        enter_fault("conf_latch", G, R, R, G, 3'd1);
        flash("flash_conf", 3, G, R, R, G, 1'b0);
        flash("clr_rejected", 1, G, R, R, G, 1'b1);
        flash("flash_after_drop", 4, R, R, R, R, 1'b0);
        clear_fault("clear1");
        run("post_clear", G, R, R, R);

        // Causes 2 and 3 together: code 2 wins.
        run("simul_first", BAD, Y, G, R);
        enter_fault("simul_latch", BAD, Y, G, R, 3'd2);
        flash("flash_simul", 2, R, R, R, R, 1'b0);
        clear_fault("clear2");
        run("post_clear2", G, R, R, R);

        // M1 jumps from green straight to red.
`ifdef SCM_YELLOW_CHECK_EN
        enter_fault("skip_yellow", R, R, R, R, 3'd4);
        flash("flash_skip", 2, R, R, R, R, 1'b0);
        clear_fault("clear3");
        run("post_clear3", G, R, R, R);
`else
        run("skip_yellow_off", R, R, R, R);
        run("post_skip", G, R, R, R);
`endif

        // Reset mid-FAULT clears everything including fault_cnt.
        run("rst_conf_first", G, R, R, G);
        enter_fault("rst_conf_latch", G, R, R, G, 3'd1);
        flash("rst_flash", 2, G, R, R, G, 1'b0);
        exp_cnt = 8'd0;
        step(1'b1, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "rst_mid_fault");

        // Reset mid-RECOVER restarts the all-red interval.
        step(1'b0, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "recover_part");
        step(1'b0, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "recover_part");
        step(1'b1, R, R, R, R, 1'b0, ev(R, R, R, R, 1'b0, 3'd0, 8'd0, 1'b1), "rst_mid_recover");
        allred("release2");
        run("after_rst", G, R, R, R);
        run("after_rst", Y, R, R, R);
        run("after_rst", R, R, R, R);

        // Let the monitor drain, then report.
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_conflict_monitor.md
# signal_conflict_monitor

Safety stage between the T-intersection light controller and the lamp drivers. It registers the four 3-bit lamp codes from the controller (M1, M2, MT, S), checks them every cycle for conflicting permissive indications, invalid codes and skipped yellow intervals, and passes them through to the lamps. On a confirmed fault it latches, forces all-way flashing red, and holds the controller in reset until an operator clear and an all-red recovery interval complete.

## Interface
- FILTER_CYC, 2, consecutive cycles a conflict or invalid condition must persist before latching (1..255)
- ALLRED_CYC, 4, all-red cycles after reset and after a cleared fault (1..255)
- FLASH_HALF, 4, cycles per flash half-period in FAULT (1..255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_M1, in_M2, in_MT, in_S  in  3 each  controller lamp codes: 100 red, 010 yellow, 001 green
- clr_req  in  1  operator fault-clear pulse
- lamp_M1, lamp_M2, lamp_MT, lamp_S  out  3 each  registered lamp drive
- fault  out  1  latched fault indication
- fault_code  out  3  cause of latched fault; 0 = none
- fault_cnt  out  8  saturating count of latched faults since reset
- ctl_hold  out  1  high in RECOVER and FAULT; tied to the controller reset

## Operation
- Permissive means code 010 or 001. Invalid means the code is not one-hot.
- Cause priority, lowest code wins: 1 = S permissive with any of M1, M2 or MT permissive. 2 = MT permissive with M2 permissive. 3 = any input invalid. 4 = any lane going directly from 001 to 100 between consecutive cycles.
- M1+M2 and M1+MT permissive together are legal.
- Filter counter: increments each cycle a cause 1–3 is present and clears on the first clean cycle.
- FSM states:
  - RECOVER: lamps 100, ctl_hold=1. Count ALLRED_CYC cycles, then go to RUN.
  - RUN: lamp_x <= in_x. Go to FAULT when a cause is confirmed.
  - FAULT: fault=1, ctl_hold=1. All lamps alternate 100 and 000, each for FLASH_HALF cycles, starting with 100. Inputs are ignored for cause detection except to gate the clear.
- FAULT exit: clr_req is accepted only when no cause 1–3 is present on the inputs that cycle. On acceptance go to RECOVER; fault and fault_code drop to 0 on that same edge. A clr_req that is not accepted is dropped, not queued.
- fault_code is captured on entry to FAULT.
- fault_cnt increments on each entry to FAULT and saturates at 255.
- Cause 4 uses a per-lane previous-code register, updated only in RUN. The register is loaded with 100 on entry to RUN.

## Timing
- Reset values: state RECOVER, RECOVER counter 0, lamps 100, fault 0, fault_code 0, fault_cnt 0, ctl_hold 1, flash phase 0, previous codes 100, filter 0.
- RUN pass-through latency: 1 cycle.
- Cause 1–3 confirmation: the condition must be present at FILTER_CYC consecutive rising edges. FAULT outputs appear at the edge that samples the FILTER_CYC-th occurrence.
- Cause 4: bypasses the filter. FAULT outputs appear at the edge sampling the offending 100.
- Simultaneous causes: fault_code takes the lowest code.
- Reset release: ctl_hold and lamps 100 persist for exactly ALLRED_CYC cycles, then RUN. The first pass-through value appears on the following edge.
- Asserting rst mid-FAULT or mid-RECOVER restarts from the reset values; fault_cnt clears.
- clr_req in RUN or RECOVER: ignored.

## Configuration
- SCM_YELLOW_CHECK_EN defined: cause 4 detection is compiled in.
- SCM_YELLOW_CHECK_EN undefined: cause 4 is never raised, the previous-code registers are omitted, and code 4 never appears on fault_code.

## Test plan
- Reset release with inputs all 100:
  - lamps 100 and ctl_hold 1 for 4 cycles;
  - then RUN, with lamp_M1 following in_M1 one cycle later;
  - fault 0, fault_cnt 0.
- Legal controller sequence over 3 loops:
  - sequence: M1/M2 green, M2 yellow, MT green, M1/MT yellow, S green, S yellow;
  - required: no fault, and every lamp equals its input delayed by 1 cycle.
- Conflict S=001 with M1=001:
  - held 2 cycles: fault=1, fault_code=1, fault_cnt=1, lamps flash 100×4 then 000×4;
  - same stimulus held only 1 cycle: no fault.
- Simultaneous causes: MT=001, M2=010 and M1=011 for 2 cycles -> fault_code=2.
- Skipped yellow, in_M1 changing 001->100:
  - with SCM_YELLOW_CHECK_EN: fault_code=4 on that edge;
  - without the macro: no fault.
- Clear and reset behaviour:
  - clr_req in FAULT with conflict still present: FAULT retained;
  - after the conflict is removed, clr_req -> RECOVER, fault 0, 4 all-red cycles, then RUN with fault_cnt=1;
  - rst asserted mid-FAULT -> fault_cnt 0.
